// File: rtl/uart_hex_rx.sv
// 8N1 UART receiver that assembles LF-terminated ASCII-hex frames into a wide word.
// Malformed frames pulse o_Rx_Error and are dropped until the next LF.
module uart_hex_rx #(
  parameter int CLKS_PER_BIT = 2,
  parameter int NUM_NIBBLES  = 64
) (
  input  logic                     i_Clock,
  input  logic                     i_Reset,
  input  logic                     i_Rx_Serial,
  output logic [4*NUM_NIBBLES-1:0] o_Rx_Word,
  output logic                     o_Rx_DV,
  output logic                     o_Rx_Error,
  output logic                     o_Rx_Active
);

  localparam int W   = 4 * NUM_NIBBLES;
  localparam int CW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int NCW = $clog2(NUM_NIBBLES + 1);
  localparam logic [CW-1:0]  CNT_MID  = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [NCW-1:0] NIB_FULL = NCW'(NUM_NIBBLES);
  localparam logic [7:0]     CH_LF    = 8'h0A;
  localparam logic [7:0]     CH_CR    = 8'h0D;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} bit_state_t;

  bit_state_t     state;
  logic           rx_meta, rx_sync;
  logic [CW-1:0]  clk_cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     rx_byte;
  logic           byte_stb;
  logic           frame_err;
  logic [NCW-1:0] nib_cnt;
  logic [W-1:0]   shadow;
  logic           discard;
  logic [4:0]     hex;

  // Returns {valid, nibble}; valid is 0 for anything that is not an ASCII hex digit.
  function automatic logic [4:0] hex_val(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39)
      return {1'b1, c[3:0]};
    if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
      return {1'b1, c[3:0] + 4'd9};
    return 5'd0;
  endfunction

  assign hex         = hex_val(rx_byte);
  assign o_Rx_Active = (state != S_IDLE);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= i_Rx_Serial;
      rx_sync <= rx_meta;
    end
  end

  // Bit FSM: the stop bit is sampled at mid-bit and the FSM returns to IDLE
  // there, so a start bit immediately following it is still caught.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state     <= S_IDLE;
      clk_cnt   <= '0;
      bit_idx   <= '0;
      rx_byte   <= '0;
      byte_stb  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_stb <= 1'b0;
      case (state)
        S_IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          if (!rx_sync) state <= S_START;
        end
        S_START: begin
          if (clk_cnt == CNT_MID) begin
            clk_cnt <= '0;
            state   <= rx_sync ? S_IDLE : S_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (clk_cnt != CNT_LAST) begin
            clk_cnt <= clk_cnt + 1'b1;
          end else begin
            clk_cnt          <= '0;
            rx_byte[bit_idx] <= rx_sync;
            bit_idx          <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= S_STOP;
          end
        end
        S_STOP: begin
          if (clk_cnt != CNT_LAST) begin
            clk_cnt <= clk_cnt + 1'b1;
          end else begin
            clk_cnt   <= '0;
            byte_stb  <= 1'b1;
            frame_err <= !rx_sync;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      o_Rx_Word  <= '0;
      o_Rx_DV    <= 1'b0;
      o_Rx_Error <= 1'b0;
      nib_cnt    <= '0;
      shadow     <= '0;
      discard    <= 1'b0;
    end else begin
      o_Rx_DV    <= 1'b0;
      o_Rx_Error <= 1'b0;
      if (byte_stb) begin
        if (discard) begin
          if (!frame_err && rx_byte == CH_LF) begin
            discard <= 1'b0;
            nib_cnt <= '0;
          end
        end else if (frame_err) begin
          o_Rx_Error <= 1'b1;
          discard    <= 1'b1;
        end else if (hex[4]) begin
          if (nib_cnt != NIB_FULL) begin
            shadow  <= {shadow[W-5:0], hex[3:0]};
            nib_cnt <= nib_cnt + 1'b1;
          end else begin
            o_Rx_Error <= 1'b1;
            discard    <= 1'b1;
          end
        end else if (rx_byte == CH_CR) begin
          nib_cnt <= nib_cnt;
        end else if (rx_byte == CH_LF) begin
          nib_cnt <= '0;
          if (nib_cnt == NIB_FULL) begin
            o_Rx_Word <= shadow;
            o_Rx_DV   <= 1'b1;
          end else begin
            o_Rx_Error <= 1'b1;
          end
        end else begin
          o_Rx_Error <= 1'b1;
          discard    <= 1'b1;
        end
      end
    end
  end

endmodule
